// File: rtl/max_timing_select.sv
// rtl/max_timing_select.sv - picks the axis with the largest total move time
// Snapshots all axes on start, then compares one axis per cycle; ties go to the lowest index.
module max_timing_select #(
   parameter  int N_AXES = 4,
   parameter  int N_SEG  = 4,
   parameter  int T_W    = 64,
   parameter  int N_PAR  = 5,
   parameter  int P_W    = 32,
   localparam int AX_W   = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [N_AXES-1:0]             axis_en,
   input  logic [N_AXES*N_SEG*T_W-1:0]   timing_flat,
   input  logic [N_AXES*N_PAR*P_W-1:0]   params_flat,
   output logic                          busy,
   output logic                          finish,
   output logic [N_SEG*T_W-1:0]          max_timing_flat,
   output logic [N_PAR*P_W-1:0]          max_params_flat,
   output logic [AX_W-1:0]               max_axis,
   output logic                          max_valid
);

   localparam int TV_W = N_SEG * T_W;
   localparam int PV_W = N_PAR * P_W;
   localparam int LAST = N_AXES - 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                       state_q, state_d;
   logic [N_AXES-1:0]            en_q, en_d;
   logic [N_AXES*TV_W-1:0]       timing_q, timing_d;
   logic [N_AXES*PV_W-1:0]       params_q, params_d;
   logic [AX_W-1:0]              idx_q, idx_d;
   logic [AX_W-1:0]              cand_axis_q, cand_axis_d;
   logic                         cand_valid_q, cand_valid_d;
   logic                         finish_q, finish_d;
   logic [TV_W-1:0]              max_timing_q, max_timing_d;
   logic [PV_W-1:0]              max_params_q, max_params_d;
   logic [AX_W-1:0]              max_axis_q, max_axis_d;
   logic                         max_valid_q, max_valid_d;

   logic [T_W-1:0]               scan_key;
   logic [T_W-1:0]               cand_key;
   logic                         take;
   logic [AX_W-1:0]              nxt_axis;
   logic                         nxt_valid;

   always_comb begin
      state_d      = state_q;
      en_d         = en_q;
      timing_d     = timing_q;
      params_d     = params_q;
      idx_d        = idx_q;
      cand_axis_d  = cand_axis_q;
      cand_valid_d = cand_valid_q;
      finish_d     = 1'b0;
      max_timing_d = max_timing_q;
      max_params_d = max_params_q;
      max_axis_d   = max_axis_q;
      max_valid_d  = max_valid_q;

      scan_key  = timing_q[(int'(idx_q) * N_SEG + N_SEG - 1) * T_W +: T_W];
      cand_key  = timing_q[(int'(cand_axis_q) * N_SEG + N_SEG - 1) * T_W +: T_W];
      take      = en_q[idx_q] && (!cand_valid_q || (scan_key > cand_key));
      nxt_axis  = take ? idx_q : cand_axis_q;
      nxt_valid = cand_valid_q | take;

      case (state_q)
         IDLE: begin
            // finish_q keeps busy high in the result cycle, so a start there is dropped
            if (start && !finish_q) begin
               en_d         = axis_en;
               timing_d     = timing_flat;
               params_d     = params_flat;
               cand_axis_d  = '0;
               cand_valid_d = axis_en[0];
               idx_d        = (N_AXES > 1) ? AX_W'(1) : '0;
               if (N_AXES == 1) begin
                  finish_d     = 1'b1;
                  max_valid_d  = axis_en[0];
                  max_axis_d   = '0;
                  max_timing_d = axis_en[0] ? timing_flat[TV_W-1:0] : '0;
                  max_params_d = axis_en[0] ? params_flat[PV_W-1:0] : '0;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            cand_axis_d  = nxt_axis;
            cand_valid_d = nxt_valid;
            if (idx_q == AX_W'(LAST)) begin
               state_d      = IDLE;
               finish_d     = 1'b1;
               max_valid_d  = nxt_valid;
               max_axis_d   = nxt_valid ? nxt_axis : '0;
               max_timing_d = nxt_valid ? timing_q[int'(nxt_axis) * TV_W +: TV_W] : '0;
               max_params_d = nxt_valid ? params_q[int'(nxt_axis) * PV_W +: PV_W] : '0;
            end else begin
               idx_d = idx_q + AX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         en_q         <= '0;
         timing_q     <= '0;
         params_q     <= '0;
         idx_q        <= '0;
         cand_axis_q  <= '0;
         cand_valid_q <= 1'b0;
         finish_q     <= 1'b0;
         max_timing_q <= '0;
         max_params_q <= '0;
         max_axis_q   <= '0;
         max_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         timing_q     <= timing_d;
         params_q     <= params_d;
         idx_q        <= idx_d;
         cand_axis_q  <= cand_axis_d;
         cand_valid_q <= cand_valid_d;
         finish_q     <= finish_d;
         max_timing_q <= max_timing_d;
         max_params_q <= max_params_d;
         max_axis_q   <= max_axis_d;
         max_valid_q  <= max_valid_d;
      end
   end

   assign busy            = (state_q == SCAN) || finish_q;
   assign finish          = finish_q;
   assign max_timing_flat = max_timing_q;
   assign max_params_flat = max_params_q;
   assign max_axis        = max_axis_q;
   assign max_valid       = max_valid_q;

endmodule
